// File: rtl/fb_swap_controller_if.sv
// Renderer write path and framebuffer write ports of the swap controller.
// The controller takes the slave side; the renderer/framebuffer side uses master.
interface fb_swap_controller_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 4
);
  logic              req1_en;
  logic              req2_en;
  logic [ADDR_W-1:0] req1_addr;
  logic [ADDR_W-1:0] req2_addr;
  logic [DATA_W-1:0] req1_data;
  logic [DATA_W-1:0] req2_data;
  logic              wr_ready;

  logic              wr1_en;
  logic              wr2_en;
  logic [ADDR_W-1:0] addr_wr1;
  logic [ADDR_W-1:0] addr_wr2;
  logic [DATA_W-1:0] data_wr1;
  logic [DATA_W-1:0] data_wr2;

  modport master (
    output req1_en, req2_en, req1_addr, req2_addr, req1_data, req2_data,
    input  wr_ready, wr1_en, wr2_en, addr_wr1, addr_wr2, data_wr1, data_wr2
  );

  modport slave (
    input  req1_en, req2_en, req1_addr, req2_addr, req1_data, req2_data,
    output wr_ready, wr1_en, wr2_en, addr_wr1, addr_wr2, data_wr1, data_wr2
  );
endinterface

// File: rtl/fb_swap_controller.sv
// Double-buffer sequencer: swaps front/back on a vsync fall after frame_done, then clears
// the new back buffer two pixels per cycle. Optional macro FB_SWAP_DIV_EN limits swap rate.
module fb_swap_controller #(
  parameter int                FB_SIZE     = 307200,
  parameter int                ADDR_W      = 19,
  parameter int                DATA_W      = 4,
  parameter logic [DATA_W-1:0] CLEAR_COLOR = '0,
  parameter int                SWAP_DIV    = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        vsync,
  input  logic        frame_done,
  output logic        render_start,
  output logic        read_pick,
  output logic        busy,
  output logic [15:0] frame_count,
  output logic        oob_err,
  fb_swap_controller_if.slave bus
);

  typedef enum logic [1:0] {RENDER, WAIT_VSYNC, SWAP, CLEAR} state_t;

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(FB_SIZE);
  localparam logic [ADDR_W:0] TWO   = (ADDR_W+1)'(2);

  if ((FB_SIZE % 2) != 0 || FB_SIZE < 2 || SWAP_DIV < 1 || SWAP_DIV > 256) begin : g_param_check
    $error("fb_swap_controller: FB_SIZE must be even and SWAP_DIV within 1..256");
  end

  state_t            state, state_next;
  logic [ADDR_W-1:0] clear_addr, clear_addr_next;
  logic              read_pick_next;
  logic [15:0]       frame_count_next;
  logic              oob_next;
  logic              render_start_next;
  logic              vs_q;
  logic              fall;
  logic              swap_ok;
  logic              clear_last;
  logic              in1, in2, acc1, acc2;
  logic              wr1_en_q, wr2_en_q, wr1_en_next, wr2_en_next;
  logic [ADDR_W-1:0] addr1_q, addr2_q, addr1_next, addr2_next;
  logic [DATA_W-1:0] data1_q, data2_q, data1_next, data2_next;

  assign fall       = vs_q & ~vsync;
  assign clear_last = ({1'b0, clear_addr} + TWO) >= LIMIT;
  assign in1        = {1'b0, bus.req1_addr} < LIMIT;
  assign in2        = {1'b0, bus.req2_addr} < LIMIT;
  // Port 2 yields to port 1 on an address clash so the BRAM never sees two writes to one word.
  assign acc1       = bus.req1_en & in1;
  assign acc2       = bus.req2_en & in2 & ~(acc1 & (bus.req2_addr == bus.req1_addr));

`ifdef FB_SWAP_DIV_EN
  logic [7:0] div_cnt, div_cnt_next;
  assign swap_ok = fall & (({1'b0, div_cnt} + 9'd1) >= 9'(SWAP_DIV));
`else
  assign swap_ok = fall;
`endif

  assign busy         = (state != RENDER);
  assign bus.wr_ready = (state == RENDER);
  assign bus.wr1_en   = wr1_en_q;
  assign bus.wr2_en   = wr2_en_q;
  assign bus.addr_wr1 = addr1_q;
  assign bus.addr_wr2 = addr2_q;
  assign bus.data_wr1 = data1_q;
  assign bus.data_wr2 = data2_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= CLEAR;
      clear_addr   <= '0;
      read_pick    <= 1'b0;
      frame_count  <= 16'd0;
      oob_err      <= 1'b0;
      render_start <= 1'b0;
      vs_q         <= 1'b0;
      wr1_en_q     <= 1'b0;
      wr2_en_q     <= 1'b0;
      addr1_q      <= '0;
      addr2_q      <= '0;
      data1_q      <= '0;
      data2_q      <= '0;
`ifdef FB_SWAP_DIV_EN
      div_cnt      <= 8'd0;
`endif
    end else begin
      state        <= state_next;
      clear_addr   <= clear_addr_next;
      read_pick    <= read_pick_next;
      frame_count  <= frame_count_next;
      oob_err      <= oob_next;
      render_start <= render_start_next;
      vs_q         <= vsync;
      wr1_en_q     <= wr1_en_next;
      wr2_en_q     <= wr2_en_next;
      addr1_q      <= addr1_next;
      addr2_q      <= addr2_next;
      data1_q      <= data1_next;
      data2_q      <= data2_next;
`ifdef FB_SWAP_DIV_EN
      div_cnt      <= div_cnt_next;
`endif
    end
  end

  always_comb begin
    state_next        = state;
    clear_addr_next   = clear_addr;
    read_pick_next    = read_pick;
    frame_count_next  = frame_count;
    oob_next          = oob_err;
    render_start_next = 1'b0;
    wr1_en_next       = 1'b0;
    wr2_en_next       = 1'b0;
    addr1_next        = '0;
    addr2_next        = '0;
    data1_next        = '0;
    data2_next        = '0;
`ifdef FB_SWAP_DIV_EN
    div_cnt_next      = div_cnt;
    if (fall && div_cnt != 8'hFF) div_cnt_next = div_cnt + 8'd1;
`endif

    case (state)
      RENDER: begin
        if (acc1) begin
          wr1_en_next = 1'b1;
          addr1_next  = bus.req1_addr;
          data1_next  = bus.req1_data;
        end
        if (acc2) begin
          wr2_en_next = 1'b1;
          addr2_next  = bus.req2_addr;
          data2_next  = bus.req2_data;
        end
        if ((bus.req1_en & ~in1) | (bus.req2_en & ~in2)) oob_next = 1'b1;
        if (frame_done) state_next = WAIT_VSYNC;
      end
      WAIT_VSYNC: begin
        if (swap_ok) state_next = SWAP;
      end
      SWAP: begin
        read_pick_next   = ~read_pick;
        frame_count_next = frame_count + 16'd1;
        clear_addr_next  = '0;
        state_next       = CLEAR;
`ifdef FB_SWAP_DIV_EN
        div_cnt_next     = 8'd0;
`endif
      end
      CLEAR: begin
        wr1_en_next     = 1'b1;
        wr2_en_next     = 1'b1;
        addr1_next      = clear_addr;
        addr2_next      = clear_addr + ADDR_W'(1);
        data1_next      = CLEAR_COLOR;
        data2_next      = CLEAR_COLOR;
        clear_addr_next = clear_addr + ADDR_W'(2);
        if (clear_last) begin
          state_next        = RENDER;
          render_start_next = 1'b1;
        end
      end
      default: state_next = CLEAR;
    endcase
  end

endmodule

// File: tb/tb_fb_swap_controller.sv
// Bench for fb_swap_controller with a 16-pixel buffer: table-driven render writes, a write
// scoreboard, and hand sequences for swap, clear, mid-clear reset and (FB_SWAP_DIV_EN) rate limiting.
module tb_fb_swap_controller;

  localparam int FB_SIZE = 16;
  localparam int ADDR_W  = 19;
  localparam int DATA_W  = 4;
`ifdef FB_SWAP_DIV_EN
  localparam int SWAP_DIV = 3;
`else
  localparam int SWAP_DIV = 1;
`endif

  typedef struct {
    logic              r1_en;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_data;
    logic              r2_en;
    logic [ADDR_W-1:0] r2_addr;
    logic [DATA_W-1:0] r2_data;
    logic              exp_en1;
    logic              exp_en2;
    logic              exp_oob;
  } vec_t;

  typedef struct packed {
    logic              en1;
    logic [ADDR_W-1:0] a1;
    logic [DATA_W-1:0] d1;
    logic              en2;
    logic [ADDR_W-1:0] a2;
    logic [DATA_W-1:0] d2;
  } wr_t;

  logic        clock;
  logic        reset;
  logic        vsync;
  logic        frame_done;
  logic        render_start;
  logic        read_pick;
  logic        busy;
  logic [15:0] frame_count;
  logic        oob_err;

  int   checks;
  int   errors;
  int   write_cycles;
  wr_t  exp_q[$];
  vec_t vecs[8];

  fb_swap_controller_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fb_swap_controller #(
    .FB_SIZE(FB_SIZE), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .CLEAR_COLOR(4'h0), .SWAP_DIV(SWAP_DIV)
  ) dut (
    .clock(clock), .reset(reset), .vsync(vsync), .frame_done(frame_done),
    .render_start(render_start), .read_pick(read_pick), .busy(busy),
    .frame_count(frame_count), .oob_err(oob_err), .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic bit matchWrite(input wr_t g, input wr_t e);
    bit ok = (g.en1 === e.en1) && (g.en2 === e.en2);
    if (e.en1 && (g.a1 !== e.a1 || g.d1 !== e.d1)) ok = 1'b0;
    if (e.en2 && (g.a2 !== e.a2 || g.d2 !== e.d2)) ok = 1'b0;
    return ok;
  endfunction

  // Every framebuffer write cycle must match the oldest expectation in the scoreboard.
  always @(negedge clock) begin
    wr_t got;
    wr_t exp_w;
    if (bus.wr1_en === 1'b1 || bus.wr2_en === 1'b1) begin
      write_cycles++;
      got = {bus.wr1_en, bus.addr_wr1, bus.data_wr1, bus.wr2_en, bus.addr_wr2, bus.data_wr2};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write: got %h, expected no write", got);
      end else begin
        exp_w = exp_q.pop_front();
        if (!matchWrite(got, exp_w)) begin
          errors++;
          $display("[TB] FAIL scoreboard_write: got %h, expected %h", got, exp_w);
        end
      end
    end
  end

  task automatic stepCycle();
    @(negedge clock);
    #1;
  endtask

  task automatic idleInputs();
    bus.req1_en   = 1'b0;
    bus.req2_en   = 1'b0;
    bus.req1_addr = '0;
    bus.req2_addr = '0;
    bus.req1_data = '0;
    bus.req2_data = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    wr_t e;
    bus.req1_en   = v.r1_en;
    bus.req1_addr = v.r1_addr;
    bus.req1_data = v.r1_data;
    bus.req2_en   = v.r2_en;
    bus.req2_addr = v.r2_addr;
    bus.req2_data = v.r2_data;
    e = {v.exp_en1, v.r1_addr, v.r1_data, v.exp_en2, v.r2_addr, v.r2_data};
    if (v.exp_en1 || v.exp_en2) exp_q.push_back(e);
  endtask

  task automatic pushClear();
    for (int i = 0; i < FB_SIZE / 2; i++)
      exp_q.push_back({1'b1, ADDR_W'(2 * i), 4'h0, 1'b1, ADDR_W'(2 * i + 1), 4'h0});
  endtask

  task automatic waitRenderStart(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 4 * FB_SIZE && !seen; i++) begin
      stepCycle();
      if (render_start === 1'b1) seen = 1'b1;
    end
    checkOutput({name, "_render_start_seen"}, 32'(seen), 32'd1);
    checkOutput({name, "_clear_cycles"}, write_cycles, FB_SIZE / 2);
    checkOutput({name, "_wr_ready"}, 32'(bus.wr_ready), 32'd1);
    checkOutput({name, "_busy_low"}, 32'(busy), 32'd0);
    stepCycle();
    checkOutput({name, "_render_start_pulse"}, 32'(render_start), 32'd0);
  endtask

  task automatic swapSequence(input logic exp_pick, input logic [15:0] exp_fc);
    for (int i = 1; i < SWAP_DIV; i++) begin
      vsync = 1'b0;
      stepCycle();
      vsync = 1'b1;
      stepCycle();
      checkOutput($sformatf("div_fall%0d_no_swap", i), 32'(read_pick), 32'(~exp_pick));
      checkOutput($sformatf("div_fall%0d_busy", i), 32'(busy), 32'd1);
    end
    write_cycles = 0;
    pushClear();
    vsync = 1'b0;
    stepCycle();
    vsync = 1'b1;
    stepCycle();
    checkOutput("swap_read_pick", 32'(read_pick), 32'(exp_pick));
    checkOutput("swap_frame_count", 32'(frame_count), 32'(exp_fc));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 19'd5,  4'hA, 1'b1, 19'd5,  4'h3, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 19'd3,  4'h1, 1'b1, 19'd4,  4'h2, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 19'd0,  4'hF, 1'b1, 19'd15, 4'h7, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 19'd16, 4'h5, 1'b0, 19'd0,  4'h0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 19'd0,  4'h0, 1'b1, 19'd9,  4'hC, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 19'd2,  4'h6, 1'b1, 19'd31, 4'h1, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 19'd0,  4'h0, 1'b0, 19'd0,  4'h0, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 19'd15, 4'h8, 1'b1, 19'd15, 4'h9, 1'b1, 1'b0, 1'b1};

    checks       = 0;
    errors       = 0;
    write_cycles = 0;
    reset        = 1'b1;
    vsync        = 1'b1;
    frame_done   = 1'b0;
    idleInputs();

    $display("[TB] reset and boot clear");
    repeat (3) stepCycle();
    checkOutput("reset_busy", 32'(busy), 32'd1);
    checkOutput("reset_wr_ready", 32'(bus.wr_ready), 32'd0);
    checkOutput("reset_render_start", 32'(render_start), 32'd0);
    checkOutput("reset_read_pick", 32'(read_pick), 32'd0);
    checkOutput("reset_frame_count", 32'(frame_count), 32'd0);
    checkOutput("reset_oob_err", 32'(oob_err), 32'd0);
    checkOutput("reset_wr_en", 32'({bus.wr1_en, bus.wr2_en}), 32'd0);
    write_cycles = 0;
    pushClear();
    reset = 1'b0;
    waitRenderStart("boot");
    checkOutput("boot_read_pick", 32'(read_pick), 32'd0);
    checkOutput("boot_frame_count", 32'(frame_count), 32'd0);

    $display("[TB] render write vectors");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      stepCycle();
      checkOutput($sformatf("vec%0d_wr1_en", i), 32'(bus.wr1_en), 32'(vecs[i].exp_en1));
      checkOutput($sformatf("vec%0d_wr2_en", i), 32'(bus.wr2_en), 32'(vecs[i].exp_en2));
      checkOutput($sformatf("vec%0d_oob_err", i), 32'(oob_err), 32'(vecs[i].exp_oob));
    end
    idleInputs();

    $display("[TB] frame_done with a same-cycle write, then wait for vsync");
    applyStimulus('{1'b1, 19'd7, 4'h5, 1'b0, 19'd0, 4'h0, 1'b1, 1'b0, 1'b1});
    frame_done = 1'b1;
    stepCycle();
    frame_done = 1'b0;
    checkOutput("done_cycle_write", 32'(bus.wr1_en), 32'd1);
    checkOutput("wait_busy", 32'(busy), 32'd1);
    checkOutput("wait_wr_ready", 32'(bus.wr_ready), 32'd0);
    bus.req1_en   = 1'b1;
    bus.req1_addr = 19'd1;
    bus.req1_data = 4'h2;
    bus.req2_en   = 1'b1;
    bus.req2_addr = 19'd2;
    for (int i = 0; i < 10; i++) begin
      frame_done = (i == 3);
      stepCycle();
    end
    frame_done = 1'b0;
    idleInputs();
    checkOutput("wait_no_write", 32'({bus.wr1_en, bus.wr2_en}), 32'd0);
    checkOutput("wait_no_swap", 32'(read_pick), 32'd0);

    $display("[TB] first swap");
    swapSequence(1'b1, 16'd1);
`ifndef FB_SWAP_DIV_EN
    vsync = 1'b0;
    stepCycle();
    vsync = 1'b1;
`endif
    waitRenderStart("swap1");
    checkOutput("swap1_frame_count_hold", 32'(frame_count), 32'd1);
    checkOutput("swap1_oob_sticky", 32'(oob_err), 32'd1);

    $display("[TB] second swap");
    frame_done = 1'b1;
    stepCycle();
    frame_done = 1'b0;
    swapSequence(1'b0, 16'd2);
    waitRenderStart("swap2");

    $display("[TB] third swap with reset mid-clear");
    frame_done = 1'b1;
    stepCycle();
    frame_done = 1'b0;
    swapSequence(1'b1, 16'd3);
    for (int i = 0; i < 20 && write_cycles < 3; i++) stepCycle();
    checkOutput("mid_clear_reached", write_cycles, 32'd3);
    reset = 1'b1;
    stepCycle();
    checkOutput("abort_read_pick", 32'(read_pick), 32'd0);
    checkOutput("abort_frame_count", 32'(frame_count), 32'd0);
    checkOutput("abort_oob_err", 32'(oob_err), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd1);
    checkOutput("abort_wr_en", 32'({bus.wr1_en, bus.wr2_en}), 32'd0);
    exp_q.delete();
    write_cycles = 0;
    pushClear();
    reset = 1'b0;
    waitRenderStart("reset_mid_clear");

    stepCycle();
    checkOutput("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_swap_controller.md
Name: fb_swap_controller

Overview:
Sequences the double-buffered framebuffer: owns the front/back select (read_pick) and both back-buffer write ports. It swaps buffers on a vsync falling edge once the renderer reports frame completion, then clears the new back buffer using both write ports. It then re-opens the back buffer to the renderer. It sits between the sprite/renderer write path and the framebuffer master's write and select inputs.

Parameters:
FB_SIZE, 307200, pixels per buffer (must be even)
ADDR_W, 19, write address width
DATA_W, 4, pixel data width
CLEAR_COLOR, 4'h0, value written during clear
SWAP_DIV, 1, minimum vsync falling edges between swaps (used only with FB_SWAP_DIV_EN)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
vsync  in  1  VGA vsync (synchronous to clock)
frame_done  in  1  renderer pulse: back buffer frame complete
render_start  out  1  one-cycle pulse: back buffer cleared, renderer may draw
wr_ready  out  1  high when renderer writes are accepted
req1_en, req2_en  in  1 each  renderer write request, port 1/2
req1_addr, req2_addr  in  ADDR_W each  renderer write address
req1_data, req2_data  in  DATA_W each  renderer write data
wr1_en, wr2_en  out  1 each  to framebuffer write ports
addr_wr1, addr_wr2  out  ADDR_W each  to framebuffer
data_wr1, data_wr2  out  DATA_W each  to framebuffer
read_pick  out  1  front buffer select (0: display fb0, write fb1)
busy  out  1  high in WAIT_VSYNC, SWAP, CLEAR
frame_count  out  16  completed swaps, wraps at 16'hFFFF->0
oob_err  out  1  sticky: a renderer request had addr >= FB_SIZE

Behaviour:
- Reset values: state=CLEAR, clear_addr=0, read_pick=0, frame_count=0, oob_err=0. All write enables/addresses/data=0. render_start=0, wr_ready=0, busy=1. Reset therefore clears fb1 at boot.
- Reset asserted mid-operation aborts any clear or swap immediately. The next cycle obeys the reset values.
- vsync falling edge: vs_q registered each cycle; fall = vs_q & ~vsync. vs_q resets to 0.
- All framebuffer outputs are registered: 1-cycle latency from request/state to wr*_en.
- States:
  - RENDER: wr_ready=1. Accepted write: reqN_en & addr<FB_SIZE drives wrN_en=1 with the addr/data next cycle.
    - A request with addr>=FB_SIZE is suppressed and sets oob_err.
    - Both ports same address and both enabled: port 1 written, port 2 suppressed (no BRAM collision).
    - frame_done moves to WAIT_VSYNC. A write presented in the same cycle as frame_done is still accepted.
  - WAIT_VSYNC: wr_ready=0; requests ignored (no wr*_en). frame_done ignored. On fall, move to SWAP.
  - SWAP (1 cycle): read_pick toggles, frame_count+1, clear_addr=0, move to CLEAR.
  - CLEAR: each cycle wr1_en=wr2_en=1, addr_wr1=clear_addr, addr_wr2=clear_addr+1, data=CLEAR_COLOR; clear_addr+=2.
    - When clear_addr+2>=FB_SIZE (last pair issued), move to RENDER and pulse render_start for 1 cycle on entry.
    - Clear takes exactly FB_SIZE/2 cycles.
    - vsync edges during CLEAR are ignored.
- render_start is asserted on the first RENDER cycle; wr_ready rises in that same cycle.
- busy = (state != RENDER).
- read_pick changes only in SWAP, so the display never sees a partially cleared buffer.

Optional Feature:
FB_SWAP_DIV_EN: when defined, an 8-bit counter counts vsync falling edges since the last swap; it resets in SWAP and saturates at 255.
- WAIT_VSYNC advances to SWAP only on a fall where the count+1 >= SWAP_DIV. This caps the frame rate.
- When undefined, the counter is absent and the first fall in WAIT_VSYNC swaps.

Test Plan:
- Reset with FB_SIZE=16 -> 8 CLEAR cycles writing pairs (0,1)…(14,15) with data 0, then render_start pulse; read_pick=0, frame_count=0.
- In RENDER: req1 addr 5 data 4'hA, req2 addr 5 data 4'h3 -> next cycle wr1_en=1 addr 5 data A, wr2_en=0.
- req1 addr 16 (FB_SIZE=16) -> wr1_en=0, oob_err=1 and held through subsequent frames until reset.
- frame_done, then vsync 1->0 after 10 cycles -> no wr*_en in between; SWAP sets read_pick=1, frame_count=1; 8 clear cycles follow.
- Assert reset during CLEAR at clear_addr=6 -> state restarts at clear_addr=0, read_pick=0, frame_count=0.
- With FB_SWAP_DIV_EN, SWAP_DIV=3: frame_done then three vsync falls -> swap occurs on the third fall only.
